coin_conditioner: RTL and testbench

COIN_CONDITIONER -- requirements
Module: coin_conditioner

---
 rtl/coin_conditioner.sv | 174 +++++++++++++++++
 tb/tb_coin_conditioner.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/coin_conditioner.sv
// Coin sensor conditioner: synchronizes two raw coin sensors, debounces each
// channel, and issues accept/reject pulses plus per-channel jam status.
module coin_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 1000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       COIN0_RAW,
    input  logic       COIN1_RAW,
    input  logic       ENABLE,
    output logic       M0,
    output logic       M1,
    output logic       REJ,
    output logic [1:0] JAM
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_HELD = 3'd2,
        ST_REL  = 3'd3,
        ST_JAM  = 3'd4
    } state_t;

    localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] JAM_LAST = 16'(JAM_CYCLES - 1);

    logic [1:0] raw_s;
    logic [1:0] sync1_r;
    logic [1:0] sync2_r;
    logic [1:0] qual_s;
    logic [1:0] jam_s;
    logic [1:0] acc_r;
    logic [1:0] rej_r;

    assign raw_s = {COIN1_RAW, COIN0_RAW};

    // Two-flop synchronizer for both asynchronous sensors
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    for (genvar n = 0; n < 2; n++) begin : g_ch
        state_t      state_r;
        state_t      state_nxt_s;
        logic [15:0] cnt_r;
        logic [15:0] cnt_nxt_s;
        logic        s_s;
        logic        chan_qual_s;
        logic        chan_jam_s;

        assign s_s = sync2_r[n];

        // Channel state and counter register
        always_ff @(posedge CLK) begin
            if (RESET) begin
                state_r <= ST_IDLE;
                cnt_r   <= 16'd0;
            end else begin
                state_r <= state_nxt_s;
                cnt_r   <= cnt_nxt_s;
            end
        end

        // Debounce / hold / release / jam transitions
        always_comb begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
            case (state_r)
                ST_IDLE: begin
                    if (s_s) begin
                        state_nxt_s = ST_ARM;
                        cnt_nxt_s   = 16'd1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ARM: begin
                    if (!s_s) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = 16'd0;
                    end else if (cnt_r == DEB_LAST) begin
                        state_nxt_s = ST_HELD;
                        cnt_nxt_s   = 16'd0;
                    end else begin
                        cnt_nxt_s   = cnt_r + 16'd1;
                    end
                end
                ST_HELD: begin
                    if (!s_s) begin
                        state_nxt_s = ST_REL;
                        cnt_nxt_s   = 16'd1;
                    end else if (cnt_r == JAM_LAST) begin
                        state_nxt_s = ST_JAM;
                        cnt_nxt_s   = 16'd0;
                    end else begin
                        cnt_nxt_s   = cnt_r + 16'd1;
                    end
                end
                ST_JAM: begin
                    if (!s_s) begin
                        state_nxt_s = ST_REL;
                        cnt_nxt_s   = 16'd1;
                    end else begin
                        state_nxt_s = ST_JAM;
                    end
                end
                ST_REL: begin
                    // A coin bouncing back high resumes holding without a new pulse
                    if (s_s) begin
                        state_nxt_s = ST_HELD;
                        cnt_nxt_s   = 16'd0;
                    end else if (cnt_r == DEB_LAST) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = 16'd0;
                    end else begin
                        cnt_nxt_s   = cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 16'd0;
                end
            endcase
        end

        // Qualify event and jam status decode
        always_comb begin
            chan_qual_s = 1'b0;
            chan_jam_s  = 1'b0;
            case (state_r)
                ST_ARM: begin
                    if (s_s && (cnt_r == DEB_LAST)) begin
                        chan_qual_s = 1'b1;
                    end else begin
                        chan_qual_s = 1'b0;
                    end
                end
                ST_JAM:  chan_jam_s = 1'b1;
                default: chan_jam_s = 1'b0;
            endcase
        end

        assign qual_s[n] = chan_qual_s;
        assign jam_s[n]  = chan_jam_s;
    end

    // ENABLE is captured only in the qualify cycle, then pulses are re-registered
    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc_r <= 2'b00;
            rej_r <= 2'b00;
            M0    <= 1'b0;
            M1    <= 1'b0;
            REJ   <= 1'b0;
        end else begin
            acc_r <= qual_s & {2{ENABLE}};
            rej_r <= qual_s & {2{~ENABLE}};
            M0    <= acc_r[0];
            M1    <= acc_r[1];
            REJ   <= |rej_r;
        end
    end

    assign JAM = jam_s;

endmodule

// File: tb/tb_coin_conditioner.sv
// Randomized scoreboard bench for coin_conditioner against a run-length
// reference model of the debounce, release and jam rules.
module tb_coin_conditioner;

    localparam int D = 4;
    localparam int J = 20;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       COIN0_RAW;
    logic       COIN1_RAW;
    logic       ENABLE;
    logic       M0;
    logic       M1;
    logic       REJ;
    logic [1:0] JAM;

    always #5 CLK = ~CLK;

    coin_conditioner #(.DEBOUNCE_CYCLES(D), .JAM_CYCLES(J)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .COIN0_RAW (COIN0_RAW),
        .COIN1_RAW (COIN1_RAW),
        .ENABLE    (ENABLE),
        .M0        (M0),
        .M1        (M1),
        .REJ       (REJ),
        .JAM       (JAM)
    );

    typedef struct {
        int   cyc;
        logic m0;
        logic m1;
        logic rej;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    exp_t       exp_q[$];
    logic [1:0] model_jam = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: S is raw delayed two samples; coins qualify on D
    // consecutive highs once released by D consecutive lows.
    initial begin
        logic [1:0] p1;
        logic [1:0] p2;
        logic [1:0] s;
        logic [1:0] pend;
        logic       pend_en;
        int         hi [2];
        int         lo [2];
        bit         released [2];
        bit         qrun [2];
        p1 = 2'b00; p2 = 2'b00; pend = 2'b00; pend_en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            hi[c] = 0; lo[c] = 0; released[c] = 1'b1; qrun[c] = 1'b0;
        end
        forever begin
            @(posedge CLK);
            cyc++;
            if (RESET) begin
                p1 = 2'b00; p2 = 2'b00; pend = 2'b00; model_jam = 2'b00;
                for (int c = 0; c < 2; c++) begin
                    hi[c] = 0; lo[c] = 0; released[c] = 1'b1; qrun[c] = 1'b0;
                end
            end else begin
                if (pend != 2'b00)
                    exp_q.push_back('{cyc, pend[0] & pend_en, pend[1] & pend_en, ~pend_en});
                pend = 2'b00;
                s  = p2;
                p2 = p1;
                p1 = {COIN1_RAW, COIN0_RAW};
                pend_en = ENABLE;
                for (int c = 0; c < 2; c++) begin
                    if (s[c]) begin hi[c]++; lo[c] = 0; end
                    else begin lo[c]++; hi[c] = 0; end
                    if (released[c]) begin
                        if (s[c] && hi[c] == D) begin
                            pend[c] = 1'b1; released[c] = 1'b0; qrun[c] = 1'b1;
                        end
                    end else if (!s[c]) begin
                        qrun[c] = 1'b0;
                        model_jam[c] = 1'b0;
                        if (lo[c] == D) released[c] = 1'b1;
                    end else if (!model_jam[c] && hi[c] == (qrun[c] ? D + J : J + 1)) begin
                        model_jam[c] = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT pulses, flags overdue entries
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            check("jam_status", {30'd0, JAM}, {30'd0, model_jam});
            if (M0 | M1 | REJ) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {29'd0, M0, M1, REJ}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_bits", {29'd0, M0, M1, REJ}, {29'd0, e.m0, e.m1, e.rej});
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                check("missing_pulse", 32'd0, {29'd0, e.m0, e.m1, e.rej});
            end
        end
    end

    task automatic watch(input int n, output int nm0, output int nm1, output int nrej,
                         output int nboth, output int first_m0);
        nm0 = 0; nm1 = 0; nrej = 0; nboth = 0; first_m0 = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge CLK);
            if (M0) nm0++;
            if (M1) nm1++;
            if (REJ) nrej++;
            if (M0 && M1) nboth++;
            if (M0 && first_m0 < 0) first_m0 = i - 1;
        end
    endtask

    function automatic int pick_run();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(15, 45));
        else return int'($urandom_range(1, 7));
    endfunction

    initial begin
        int nm0, nm1, nrej, nboth, first;
        int run0, run1;
        RESET = 1'b1; COIN0_RAW = 1'b0; COIN1_RAW = 1'b0; ENABLE = 1'b1;
        repeat (3) @(negedge CLK);
        check("reset_outputs", {27'd0, M0, M1, REJ, JAM}, 32'd0);
        RESET = 1'b0;
        repeat (4) @(negedge CLK);

        // single accepted coin, 10 cycles
        COIN0_RAW = 1'b1;
        watch(10, nm0, nm1, nrej, nboth, first);
        COIN0_RAW = 1'b0;
        check("coin0_latency", first, 6);
        check("coin0_m0_count", nm0, 1);
        check("coin0_m1_rej", nm1 + nrej, 0);
        repeat (12) @(negedge CLK);

        // 3-cycle glitch on coin 1
        COIN1_RAW = 1'b1;
        watch(3, nm0, nm1, nrej, nboth, first);
        COIN1_RAW = 1'b0;
        watch(12, nm0, nm1, nrej, nboth, first);
        check("glitch_no_pulse", nm1 + nrej, 0);

        // simultaneous coins
        COIN0_RAW = 1'b1; COIN1_RAW = 1'b1;
        watch(10, nm0, nm1, nrej, nboth, first);
        COIN0_RAW = 1'b0; COIN1_RAW = 1'b0;
        check("dual_together", nboth, 1);
        check("dual_m0_count", nm0, 1);
        repeat (12) @(negedge CLK);

        // rejected coin 1 while disabled; ENABLE flips back mid-hold
        ENABLE = 1'b0; COIN1_RAW = 1'b1;
        watch(6, nm0, nm1, nrej, nboth, first);
        ENABLE = 1'b1;
        begin
            int a, b, r, x, f;
            watch(4, a, b, r, x, f);
            nm1 += b; nrej += r;
        end
        COIN1_RAW = 1'b0;
        check("reject_rej_count", nrej, 1);
        check("reject_m1_quiet", nm1, 0);
        repeat (12) @(negedge CLK);

        // jam: hold coin 0 for 40 cycles
        COIN0_RAW = 1'b1;
        watch(40, nm0, nm1, nrej, nboth, first);
        check("jam_single_m0", nm0, 1);
        check("jam_asserted", {30'd0, JAM}, 32'd1);
        COIN0_RAW = 1'b0;
        watch(15, nm0, nm1, nrej, nboth, first);
        check("jam_no_second_m0", nm0, 0);
        check("jam_cleared", {30'd0, JAM}, 32'd0);

        // reset two cycles into a coin, raw kept high
        COIN0_RAW = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        watch(12, nm0, nm1, nrej, nboth, first);
        COIN0_RAW = 1'b0;
        check("reset_recoin_latency", first, 6);
        check("reset_recoin_count", nm0, 1);
        repeat (12) @(negedge CLK);

        // randomized traffic
        run0 = 0; run1 = 0;
        for (int k = 0; k < 3000; k++) begin
            if (run0 == 0) begin COIN0_RAW = ~COIN0_RAW; run0 = pick_run(); end
            if (run1 == 0) begin COIN1_RAW = ~COIN1_RAW; run1 = pick_run(); end
            run0--; run1--;
            if ($urandom_range(0, 9) == 0) ENABLE = ~ENABLE;
            RESET = ($urandom_range(0, 399) == 0);
            @(negedge CLK);
        end
        RESET = 1'b0; COIN0_RAW = 1'b0; COIN1_RAW = 1'b0;
        repeat (30) @(negedge CLK);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
